// File: rtl/y86_fetch_stage_if.sv
// Instruction-memory port of the Y86-64 fetch stage: one 64-bit byte address out,
// ten instruction bytes and an address-error flag back.
interface y86_fetch_stage_if;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;

    modport master (
        output imem_addr,
        input  imem_data,
        input  imem_error
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output imem_error
    );
endinterface

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: PC select, instruction split/validate, next-PC prediction, F and D registers.
// Optional macro IMEM_BOUND_CHECK_EN adds an internal ADR check for f_pc > IMEM_SIZE-10.
module y86_fetch_stage #(
    parameter int          IMEM_SIZE = 4096,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    y86_fetch_stage_if.master        imem,
    input  logic                     F_stall,
    input  logic                     D_stall,
    input  logic                     D_bubble,
    input  logic [3:0]               M_icode,
    input  logic                     M_Cnd,
    input  logic [63:0]              M_valA,
    input  logic [3:0]               W_icode,
    input  logic [63:0]              W_valM,
    output logic [63:0]              F_predPC,
    output logic [2:0]               D_stat,
    output logic [3:0]               D_icode,
    output logic [3:0]               D_ifun,
    output logic [3:0]               D_rA,
    output logic [3:0]               D_rB,
    output logic [63:0]              D_valC,
    output logic [63:0]              D_valP
);
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } dreg_t;

    localparam dreg_t D_BUBBLE = '{stat: STAT_AOK, icode: 4'h1, ifun: 4'h0,
                                   ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'h0};

    logic [63:0] F_predPC_q, F_predPC_d;
    dreg_t       D_q, D_d;

    logic [63:0] f_pc;
    logic [7:0]  f_byte [10];
    logic [63:0] f_valc_noreg, f_valc_reg;
    logic        f_oob, f_adr;
    logic [3:0]  f_icode, f_ifun;
    logic        f_valid, f_need_regids, f_need_valc;
    dreg_t       f_fetch;

    genvar gi;
    for (gi = 0; gi < 10; gi++) begin : g_bytes
        assign f_byte[gi] = imem.imem_data[gi*8 +: 8];
    end
    // valC sits right after byte 0, or after the register byte when one is present.
    for (gi = 0; gi < 8; gi++) begin : g_valc
        assign f_valc_noreg[gi*8 +: 8] = f_byte[gi+1];
        assign f_valc_reg[gi*8 +: 8]   = f_byte[gi+2];
    end

    // A mispredicted jXX in M overrides a ret in W.
    always_comb begin
        if (M_icode == 4'h7 && !M_Cnd) begin
            f_pc = M_valA;
        end else if (W_icode == 4'h9) begin
            f_pc = W_valM;
        end else begin
            f_pc = F_predPC_q;
        end
    end
    assign imem.imem_addr = f_pc;

`ifdef IMEM_BOUND_CHECK_EN
    localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_SIZE) - 64'd10;
    assign f_oob = (f_pc > IMEM_LIMIT);
`else
    logic unused_imem_size;
    assign unused_imem_size = (IMEM_SIZE == 0);
    assign f_oob = 1'b0;
`endif
    assign f_adr = imem.imem_error | f_oob;

    always_comb begin
        f_icode = f_byte[0][7:4];
        f_ifun  = f_byte[0][3:0];
        if (imem.imem_error) begin
            f_icode = 4'h1;
            f_ifun  = 4'h0;
        end

        case (f_icode)
            4'h2, 4'h7:       f_valid = (f_ifun <= 4'h6);
            4'h6:             f_valid = (f_ifun <= 4'h3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
            4'h8, 4'h9, 4'hA, 4'hB: f_valid = (f_ifun == 4'h0);
            default:          f_valid = 1'b0;
        endcase

        f_need_regids = f_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        f_need_valc   = f_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};

        f_fetch.icode = f_icode;
        f_fetch.ifun  = f_ifun;
        f_fetch.ra    = f_need_regids ? f_byte[1][7:4] : 4'hF;
        f_fetch.rb    = f_need_regids ? f_byte[1][3:0] : 4'hF;
        f_fetch.valc  = !f_need_valc ? 64'h0 : (f_need_regids ? f_valc_reg : f_valc_noreg);
        f_fetch.valp  = f_pc + 64'd1 + {63'h0, f_need_regids} + (f_need_valc ? 64'd8 : 64'd0);

        if (f_adr) begin
            f_fetch.stat = STAT_ADR;
        end else if (!f_valid) begin
            f_fetch.stat = STAT_INS;
        end else if (f_icode == 4'h0) begin
            f_fetch.stat = STAT_HLT;
        end else begin
            f_fetch.stat = STAT_AOK;
        end

        // Any non-AOK status re-fetches the same PC so the front end freezes.
        if (f_fetch.stat != STAT_AOK) begin
            F_predPC_d = f_pc;
        end else if (f_icode == 4'h7 || f_icode == 4'h8) begin
            F_predPC_d = f_fetch.valc;
        end else begin
            F_predPC_d = f_fetch.valp;
        end

        if (D_stall) begin
            D_d = D_q;
        end else if (D_bubble) begin
            D_d = D_BUBBLE;
        end else begin
            D_d = f_fetch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F_predPC_q <= RESET_PC;
            D_q        <= D_BUBBLE;
        end else begin
            if (!F_stall) begin
                F_predPC_q <= F_predPC_d;
            end
            D_q <= D_d;
        end
    end

    assign F_predPC = F_predPC_q;
    assign D_stat   = D_q.stat;
    assign D_icode  = D_q.icode;
    assign D_ifun   = D_q.ifun;
    assign D_rA     = D_q.ra;
    assign D_rB     = D_q.rb;
    assign D_valC   = D_q.valc;
    assign D_valP   = D_q.valp;
endmodule

// File: tb/tb_y86_fetch_stage.sv
// Directed bench for y86_fetch_stage: stimulus pushes expected state into a scoreboard,
// a negedge monitor pops one entry per cycle and compares it with the DUT.
module tb_y86_fetch_stage;
    logic        clk;
    logic        rst;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [63:0] F_predPC;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        imem_err;
    logic [7:0]  mem [1024];

    y86_fetch_stage_if bus ();

    y86_fetch_stage dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (bus),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .M_icode  (M_icode),
        .M_Cnd    (M_Cnd),
        .M_valA   (M_valA),
        .W_icode  (W_icode),
        .W_valM   (W_valM),
        .F_predPC (F_predPC),
        .D_stat   (D_stat),
        .D_icode  (D_icode),
        .D_ifun   (D_ifun),
        .D_rA     (D_rA),
        .D_rB     (D_rB),
        .D_valC   (D_valC),
        .D_valP   (D_valP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model, 1 KiB wrapping.
    always_comb begin
        bus.imem_data = '0;
        for (int i = 0; i < 10; i++) begin
            bus.imem_data[i*8 +: 8] = mem[bus.imem_addr[9:0] + 10'(i)];
        end
    end
    assign bus.imem_error = imem_err;

    typedef struct {
        int           step;
        logic [63:0]  addr;
        logic [146:0] d;
        logic [63:0]  pc;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_no  = 0;

    function automatic logic [146:0] dv(input logic [2:0] stat, input logic [3:0] icode,
                                        input logic [3:0] ifun, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [63:0] valc,
                                        input logic [63:0] valp);
        return {stat, icode, ifun, ra, rb, valc, valp};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] addr, input logic [146:0] d, input logic [63:0] pc);
        exp_t e;
        e.step = step_no;
        e.addr = addr;
        e.d    = d;
        e.pc   = pc;
        exp_q.push_back(e);
        step_no++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (bus.imem_addr !== mon_e.addr) begin
                    n_errors++;
                    $display("FAIL step%0d imem_addr actual=%h required=%h", mon_e.step, bus.imem_addr, mon_e.addr);
                end
                n_checks++;
                if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} !== mon_e.d) begin
                    n_errors++;
                    $display("FAIL step%0d D_reg actual=%h required=%h", mon_e.step,
                             {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}, mon_e.d);
                end
                n_checks++;
                if (F_predPC !== mon_e.pc) begin
                    n_errors++;
                    $display("FAIL step%0d F_predPC actual=%h required=%h", mon_e.step, F_predPC, mon_e.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [146:0] BUB, IRMOV, HALT;

    initial begin
        BUB   = dv(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        IRMOV = dv(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10);
        HALT  = dv(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41);

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h000] = 8'h30; mem[10'h001] = 8'hF2; mem[10'h002] = 8'h0A;
        mem[10'h00A] = 8'h10;
        mem[10'h020] = 8'h70; mem[10'h021] = 8'h00; mem[10'h022] = 8'h01;
        mem[10'h029] = 8'h60; mem[10'h02A] = 8'h23;
        mem[10'h080] = 8'h61; mem[10'h081] = 8'h45;
        mem[10'h050] = 8'hF0;
        mem[10'h060] = 8'h30; mem[10'h061] = 8'hF2;
        mem[10'h070] = 8'h27; mem[10'h071] = 8'h12;
        mem[10'h090] = 8'h80; mem[10'h091] = 8'h00; mem[10'h092] = 8'h02;
        mem[10'h0A0] = 8'h50; mem[10'h0A1] = 8'h12; mem[10'h0A2] = 8'h08; mem[10'h0A3] = 8'h07;
        mem[10'h0A4] = 8'h06; mem[10'h0A5] = 8'h05; mem[10'h0A6] = 8'h04; mem[10'h0A7] = 8'h03;
        mem[10'h0A8] = 8'h02; mem[10'h0A9] = 8'h01;

        rst = 1'b1; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;
        M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'h0;
        W_icode = 4'h0; W_valM = 64'h0; imem_err = 1'b0;

        cyc(); push(64'h0, BUB, 64'h0);
        cyc(); rst = 1'b0; push(64'h0, BUB, 64'h0);
        cyc(); push(64'hA, IRMOV, 64'hA);
        cyc(); M_icode = 4'h7; M_valA = 64'h20;
        push(64'h20, dv(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'hB), 64'hB);
        cyc(); M_valA = 64'h29;
        push(64'h29, dv(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29), 64'h100);
        cyc(); M_icode = 4'h0; W_icode = 4'h9; W_valM = 64'h80;
        push(64'h80, dv(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h2B), 64'h2B);
        cyc(); M_icode = 4'h7; M_valA = 64'h40;
        push(64'h40, dv(3'd1, 4'h6, 4'h1, 4'h4, 4'h5, 64'h0, 64'h82), 64'h82);
        cyc(); M_icode = 4'h0; W_icode = 4'h0; push(64'h40, HALT, 64'h40);
        cyc(); F_stall = 1'b1; D_stall = 1'b1; push(64'h40, HALT, 64'h40);
        cyc(); push(64'h40, HALT, 64'h40);
        cyc(); D_bubble = 1'b1; push(64'h40, HALT, 64'h40);
        cyc(); D_stall = 1'b0; push(64'h40, HALT, 64'h40);
        cyc(); F_stall = 1'b0; D_bubble = 1'b0; M_icode = 4'h7; M_valA = 64'h50;
        push(64'h50, BUB, 64'h40);
        cyc(); M_valA = 64'h60; imem_err = 1'b1;
        push(64'h60, dv(3'd4, 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51), 64'h50);
        cyc(); M_valA = 64'h70; imem_err = 1'b0;
        push(64'h70, dv(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h61), 64'h60);
        cyc(); M_valA = 64'h90;
        push(64'h90, dv(3'd4, 4'h2, 4'h7, 4'h1, 4'h2, 64'h0, 64'h72), 64'h70);
        cyc(); M_valA = 64'hA0; F_stall = 1'b1;
        push(64'hA0, dv(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'h99), 64'h200);
        cyc(); M_icode = 4'h0; F_stall = 1'b0;
        push(64'h200, dv(3'd1, 4'h5, 4'h0, 4'h1, 4'h2, 64'h0102030405060708, 64'hAA), 64'h200);
        cyc(); rst = 1'b1; push(64'h0, BUB, 64'h0);
        cyc(); rst = 1'b0; push(64'h0, BUB, 64'h0);
        cyc(); push(64'hA, IRMOV, 64'hA);

        for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
